// File: rtl/req_pkg.sv
`default_nettype none
// ============================================================================
// Module      : req_pkg
// Description : Shared widths, the encoder "no request" code and an
//               index-to-one-hot decoder for the request capture stage.
// Revision    : 1.0 - initial release
// ============================================================================
package req_pkg;

    localparam int REQ_WIDTH = 16;
    localparam int CODE_W    = 8;
    localparam int IDX_W     = 4;
    localparam logic [CODE_W-1:0] NONE_CODE = 8'hF0;

    function automatic logic [REQ_WIDTH-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [REQ_WIDTH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_vec.sv
`default_nettype none
// ============================================================================
// Module      : sync_vec
// Description : WIDTH-wide, STAGES-deep flop synchronizer with synchronous
//               active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_vec #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int s = 1; s < STAGES; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/req_capture.sv
`default_nettype none
// ============================================================================
// Module      : req_capture
// Description : Synchronizes asynchronous request lines, captures rising
//               edges into a sticky pending vector and clears bits on encoder
//               acknowledge. Optional per-line enable mask via REQ_MASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module req_capture #(
    parameter int WIDTH       = req_pkg::REQ_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int CODE_W      = req_pkg::CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  req_in,
    input  logic              ack_valid,
    input  logic [CODE_W-1:0] ack_code,
    input  logic              ovf_clr,
`ifdef REQ_MASK_EN
    input  logic              mask_we,
    input  logic [WIDTH-1:0]  mask_data,
    output logic [WIDTH-1:0]  mask_q,
`endif
    output logic [WIDTH-1:0]  pending,
    output logic              pending_any,
    output logic              overflow
);

    import req_pkg::*;

    logic [WIDTH-1:0]     w_sync_q;
    logic [WIDTH-1:0]     w_mask;
    logic [WIDTH-1:0]     w_rise;
    logic [WIDTH-1:0]     w_clr;
    logic [WIDTH-1:0]     w_pending_next;
    logic [REQ_WIDTH-1:0] w_onehot;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_ack_ok;
    logic                 w_lost;

    logic [WIDTH-1:0]     r_prev;
    logic [WIDTH-1:0]     r_pending;
    logic                 r_pending_any;
    logic                 r_overflow;

    sync_vec #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (req_in),
        .o_q (w_sync_q)
    );

`ifdef REQ_MASK_EN
    logic [WIDTH-1:0] r_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '1;
        end else if (mask_we) begin
            r_mask <= mask_data;
        end
    end

    assign w_mask = r_mask;
    assign mask_q = r_mask;
`else
    assign w_mask = '1;
`endif

    // Codes with any upper bit set (including the "none" code) or an index
    // beyond WIDTH are not acknowledges.
    assign w_idx    = ack_code[IDX_W-1:0];
    assign w_ack_ok = ack_valid && (ack_code[CODE_W-1:IDX_W] == '0)
                      && ({28'd0, w_idx} < 32'(WIDTH));
    assign w_onehot = idx_to_onehot(w_idx);
    assign w_clr    = w_ack_ok ? w_onehot[WIDTH-1:0] : '0;

    // A rise on a bit being cleared this cycle keeps the bit set.
    assign w_rise         = w_sync_q & ~r_prev & w_mask;
    assign w_pending_next = w_rise | (r_pending & ~w_clr);
    assign w_lost         = |(w_rise & r_pending & ~w_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev        <= '0;
            r_pending     <= '0;
            r_pending_any <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_prev        <= w_sync_q;
            r_pending     <= w_pending_next;
            r_pending_any <= |w_pending_next;
            if (w_lost) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign pending     = r_pending;
    assign pending_any = r_pending_any;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire
